// File: rtl/exec_unit.sv
// Execute stage for the swt16 core: sampled operands feed a single-cycle ALU, an
// iterative shift-add multiplier that stalls upstream, and jump/branch resolution.
module exec_unit #(
  parameter int OP_WIDTH        = 4,
  parameter int IALU_WORD_WIDTH = 16,
  parameter int PC_WIDTH        = 12,
  parameter int REG_IDX_WIDTH   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [OP_WIDTH-1:0]        in_op,
  input  logic [IALU_WORD_WIDTH-1:0] in_src1,
  input  logic [IALU_WORD_WIDTH-1:0] in_src2,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [PC_WIDTH-1:0]        in_imm,
  input  logic [REG_IDX_WIDTH-1:0]   in_rd,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic                       out_res_valid,
  output logic [REG_IDX_WIDTH-1:0]   out_rd,
  output logic                       out_stall,
  output logic                       out_flush,
  output logic                       out_set_pc,
  output logic [PC_WIDTH-1:0]        out_new_pc
);

  localparam int W     = IALU_WORD_WIDTH;
  localparam int SH_W  = $clog2(W);
  localparam int CNT_W = $clog2(W + 1);

  localparam logic [OP_WIDTH-1:0] OP_NOP = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SLL = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_SRL = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_JMP = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OP_BEQ = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] OP_BNE = OP_WIDTH'(11);
  localparam logic [OP_WIDTH-1:0] OP_BLT = OP_WIDTH'(12);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state;
  logic [OP_WIDTH-1:0]      s_op;
  logic [W-1:0]             s_src1;
  logic [W-1:0]             s_src2;
  logic [PC_WIDTH-1:0]      s_pc;
  logic [PC_WIDTH-1:0]      s_imm;
  logic [REG_IDX_WIDTH-1:0] s_rd;
  logic [W-1:0]             mcand;
  logic [W-1:0]             mplier;
  logic [W-1:0]             acc;
  logic [CNT_W-1:0]         count;

  logic                stall;
  logic                flush;
  logic                res_valid;
  logic [W-1:0]        res;
  logic [PC_WIDTH-1:0] new_pc;
  logic                taken;

  // Stall depends on FSM state alone, so upstream never sees a combinational path from in_*.
  assign stall = (state == BUSY);

  always_comb begin
    res_valid = 1'b0;
    res       = '0;
    flush     = 1'b0;
    new_pc    = '0;
    taken     = 1'b0;
    case (s_op)
      OP_ADD: begin res_valid = 1'b1; res = s_src1 + s_src2; end
      OP_SUB: begin res_valid = 1'b1; res = s_src1 - s_src2; end
      OP_AND: begin res_valid = 1'b1; res = s_src1 & s_src2; end
      OP_OR:  begin res_valid = 1'b1; res = s_src1 | s_src2; end
      OP_XOR: begin res_valid = 1'b1; res = s_src1 ^ s_src2; end
      OP_SLL: begin res_valid = 1'b1; res = s_src1 << s_src2[SH_W-1:0]; end
      OP_SRL: begin res_valid = 1'b1; res = s_src1 >> s_src2[SH_W-1:0]; end
      OP_MUL: begin
        if (state == DONE) begin
          res_valid = 1'b1;
          res       = acc;
        end
      end
      OP_JMP: begin
        flush  = 1'b1;
        new_pc = PC_WIDTH'(s_src1 + s_src2);
      end
      OP_BEQ, OP_BNE, OP_BLT: begin
        if (s_op == OP_BEQ)      taken = (s_src1 == s_src2);
        else if (s_op == OP_BNE) taken = (s_src1 != s_src2);
        else                     taken = ($signed(s_src1) < $signed(s_src2));
        if (taken) begin
          flush  = 1'b1;
          // imm is PC-wide, so a same-width wrap-around add equals the sign-extended add.
          new_pc = s_pc + s_imm;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      s_op   <= OP_NOP;
      s_src1 <= '0;
      s_src2 <= '0;
      s_pc   <= '0;
      s_imm  <= '0;
      s_rd   <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else begin
      if (!stall) begin
        s_op   <= (flush || !in_valid) ? OP_NOP : in_op;
        s_src1 <= in_src1;
        s_src2 <= in_src2;
        s_pc   <= in_pc;
        s_imm  <= in_imm;
        s_rd   <= in_rd;
      end
      case (state)
        IDLE, DONE: begin
          if (!flush && in_valid && in_op == OP_MUL) begin
            state  <= BUSY;
            mcand  <= in_src1;
            mplier <= in_src2;
            acc    <= '0;
            count  <= CNT_W'(W);
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CNT_W'(1);
          if (count == CNT_W'(1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_stall     = stall;
  assign out_res_valid = res_valid;
  assign out_res       = res;
  assign out_rd        = res_valid ? s_rd : '0;
  assign out_flush     = flush;
  assign out_set_pc    = flush;
  assign out_new_pc    = new_pc;

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: directed and random ops, a queue-based scoreboard fed by an
// arithmetic reference model, and a negedge monitor that checks every output event.
module tb_exec_unit;

  localparam int W   = 16;
  localparam int PCW = 12;
  localparam int OPW = 4;
  localparam int RW  = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic [OPW-1:0] in_op = '0;
  logic [W-1:0]   in_src1 = '0;
  logic [W-1:0]   in_src2 = '0;
  logic [PCW-1:0] in_pc = '0;
  logic [PCW-1:0] in_imm = '0;
  logic [RW-1:0]  in_rd = '0;
  logic [W-1:0]   out_res;
  logic           out_res_valid;
  logic [RW-1:0]  out_rd;
  logic           out_stall;
  logic           out_flush;
  logic           out_set_pc;
  logic [PCW-1:0] out_new_pc;

  exec_unit #(
    .OP_WIDTH(OPW), .IALU_WORD_WIDTH(W), .PC_WIDTH(PCW), .REG_IDX_WIDTH(RW)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_pc(in_pc), .in_imm(in_imm), .in_rd(in_rd),
    .out_res(out_res), .out_res_valid(out_res_valid), .out_rd(out_rd),
    .out_stall(out_stall), .out_flush(out_flush), .out_set_pc(out_set_pc),
    .out_new_pc(out_new_pc)
  );

  // clock / reset / cycle counter
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0]    cyc;
    logic           is_res;
    logic [W-1:0]   res;
    logic [RW-1:0]  rd;
    logic           is_br;
    logic [PCW-1:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int last_flush = -10;
  int stall_lo   = -1;
  int stall_hi   = -2;

  // reference model: edge e samples the op; outputs show in cycle e (MUL: e+16)
  task automatic model(input int e, input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [PCW-1:0] pc, input logic [PCW-1:0] imm, input logic [RW-1:0] rd);
    exp_t   x;
    longint p;
    int     s, t;
    logic   tk;
    if (e == last_flush + 1) op = 0;
    x = '0;
    x.cyc = 32'(e);
    x.rd  = rd;
    case (op)
      1: begin x.is_res = 1'b1; x.res = W'(int'(a) + int'(b)); end
      2: begin x.is_res = 1'b1; x.res = W'(int'(a) - int'(b)); end
      3: begin x.is_res = 1'b1; x.res = a & b; end
      4: begin x.is_res = 1'b1; x.res = a | b; end
      5: begin x.is_res = 1'b1; x.res = a ^ b; end
      6: begin x.is_res = 1'b1; x.res = W'(int'(a) * (2 ** (int'(b) % 16))); end
      7: begin x.is_res = 1'b1; x.res = W'(int'(a) / (2 ** (int'(b) % 16))); end
      8: begin
        p = longint'(a) * longint'(b);
        x.is_res = 1'b1;
        x.res    = W'(p % 65536);
        x.cyc    = 32'(e + 16);
        stall_lo = e;
        stall_hi = e + 15;
      end
      9: begin
        x.is_br = 1'b1;
        x.pc    = PCW'((int'(a) + int'(b)) % 4096);
        last_flush = e;
      end
      10, 11, 12: begin
        if (op == 10)      tk = (a == b);
        else if (op == 11) tk = (a != b);
        else               tk = ($signed(a) < $signed(b));
        if (tk) begin
          s = int'(imm);
          if (s >= 2048) s = s - 4096;
          t = (int'(pc) + s + 4096) % 4096;
          x.is_br = 1'b1;
          x.pc    = PCW'(t);
          last_flush = e;
        end
      end
      default: ;
    endcase
    if (!x.is_res) x.rd = '0;
    if (x.is_res || x.is_br) exp_q.push_back(x);
  endtask

  // driver: waits out any stall (scrambling inputs meanwhile), then presents one op
  task automatic issue(input int op, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [PCW-1:0] pc, input logic [PCW-1:0] imm, input logic [RW-1:0] rd);
    int waited = 0;
    @(negedge clock);
    while (out_stall && waited < 40) begin
      in_valid = 1'b1;
      in_op    = OPW'($urandom_range(0, 15));
      in_src1  = W'($urandom);
      in_src2  = W'($urandom);
      in_pc    = PCW'($urandom);
      in_imm   = PCW'($urandom);
      in_rd    = RW'($urandom);
      waited++;
      @(negedge clock);
    end
    if (out_stall) begin
      n_cmp++;
      n_fail++;
      $display("FAIL stall_timeout: out_stall=%0b after %0d cycles, required 0", out_stall, waited);
    end
    in_valid = v;
    in_op    = OPW'(op);
    in_src1  = a;
    in_src2  = b;
    in_pc    = pc;
    in_imm   = imm;
    in_rd    = rd;
    model(cyc + 1, v ? op : 0, a, b, pc, imm, rd);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid = 1'b0;
      in_op    = OPW'($urandom_range(0, 15));
      in_src1  = W'($urandom);
      in_src2  = W'($urandom);
    end
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if (out_res !== '0 || out_res_valid !== 1'b0 || out_rd !== '0 || out_stall !== 1'b0 ||
        out_flush !== 1'b0 || out_set_pc !== 1'b0 || out_new_pc !== '0) begin
      n_fail++;
      $display("FAIL %s: res=%h v=%b rd=%h stall=%b flush=%b set_pc=%b pc=%h, required all 0",
               name, out_res, out_res_valid, out_rd, out_stall, out_flush, out_set_pc, out_new_pc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    exp_t x, act;
    logic exp_stall;
    if (!reset) begin
      exp_stall = (cyc >= stall_lo) && (cyc <= stall_hi);
      n_cmp++;
      if (out_stall !== exp_stall) begin
        n_fail++;
        $display("FAIL stall @%0d: got %b, required %b", cyc, out_stall, exp_stall);
      end
      while (exp_q.size() != 0 && int'(exp_q[0].cyc) < cyc) begin
        x = exp_q.pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL missing_output: nothing seen, required res_v=%b res=%h br=%b pc=%h at cycle %0d",
                 x.is_res, x.res, x.is_br, x.pc, x.cyc);
      end
      n_cmp++;
      if (out_res_valid || out_flush || out_set_pc) begin
        act.cyc    = 32'(cyc);
        act.is_res = out_res_valid;
        act.res    = out_res;
        act.rd     = out_rd;
        act.is_br  = out_flush;
        act.pc     = out_new_pc;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output @%0d: res_v=%b res=%h rd=%h flush=%b pc=%h, required none",
                   cyc, out_res_valid, out_res, out_rd, out_flush, out_new_pc);
        end else begin
          x = exp_q.pop_front();
          if (act !== x || out_set_pc !== out_flush) begin
            n_fail++;
            $display("FAIL result @%0d: got res_v=%b res=%h rd=%h flush=%b set_pc=%b pc=%h, required cyc=%0d res_v=%b res=%h rd=%h flush=set_pc=%b pc=%h",
                     cyc, out_res_valid, out_res, out_rd, out_flush, out_set_pc, out_new_pc,
                     x.cyc, x.is_res, x.res, x.rd, x.is_br, x.pc);
          end
        end
      end else if (out_res !== '0 || out_rd !== '0 || out_new_pc !== '0) begin
        n_fail++;
        $display("FAIL idle_zero @%0d: res=%h rd=%h pc=%h, required 0", cyc, out_res, out_rd, out_new_pc);
      end
    end
  end

  initial begin
    logic [W-1:0] a, b;
    int op;
    #1;
    check_zero("reset_state");
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    // directed: ALU, shifts, MUL, branches, squash, jump
    issue(1,  1'b1, 16'h7FFF, 16'h0001, 12'h000, 12'h000, 4'd3);
    issue(2,  1'b1, 16'h0000, 16'h0001, 12'h000, 12'h000, 4'd5);
    issue(6,  1'b1, 16'h0001, 16'h0013, 12'h000, 12'h000, 4'd1);
    issue(7,  1'b1, 16'h8000, 16'h000F, 12'h000, 12'h000, 4'd2);
    issue(8,  1'b1, 16'h0012, 16'h0034, 12'h000, 12'h000, 4'd4);
    issue(8,  1'b1, 16'hFFFF, 16'hFFFF, 12'h000, 12'h000, 4'd6);
    issue(5,  1'b1, 16'hA5A5, 16'h0FF0, 12'h000, 12'h000, 4'd7);
    issue(10, 1'b1, 16'h0005, 16'h0005, 12'h010, 12'hFFC, 4'd0);
    issue(1,  1'b1, 16'h0001, 16'h0001, 12'h000, 12'h000, 4'd8);
    issue(11, 1'b1, 16'h0005, 16'h0005, 12'h020, 12'h004, 4'd0);
    issue(12, 1'b1, 16'hFFFF, 16'h0001, 12'hFFE, 12'h005, 4'd0);
    issue(3,  1'b1, 16'hF0F0, 16'hFFFF, 12'h000, 12'h000, 4'd9);
    issue(9,  1'b1, 16'h0FF0, 16'h0020, 12'h000, 12'h000, 4'd0);
    issue(4,  1'b1, 16'h00F0, 16'h0F00, 12'h000, 12'h000, 4'd10);
    issue(4,  1'b1, 16'h00F0, 16'h0F00, 12'h000, 12'h000, 4'd11);
    issue(13, 1'b1, 16'h1234, 16'h4321, 12'h000, 12'h000, 4'd12);
    issue(1,  1'b0, 16'h1234, 16'h4321, 12'h000, 12'h000, 4'd12);
    idle(3);

    // reset in the middle of a multiply
    issue(8, 1'b1, 16'h1234, 16'h5678, 12'h000, 12'h000, 4'd4);
    repeat (7) @(posedge clock);
    #2 reset = 1'b1;
    in_valid = 1'b0;
    #1 check_zero("reset_mid_mul");
    exp_q.delete();
    stall_lo   = -1;
    stall_hi   = -2;
    last_flush = -10;
    @(posedge clock);
    #2 reset = 1'b0;
    issue(1, 1'b1, 16'h0001, 16'h0001, 12'h000, 12'h000, 4'd7);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 15);
      a  = W'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      issue(op, ($urandom_range(0, 7) != 0), a, b, PCW'($urandom), PCW'($urandom), RW'($urandom));
    end
    idle(25);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected outputs still queued, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
Parametrised execute stage for the swt16 core. It registers decoded operands and runs an integer ALU with add, sub, logic and shift operations. It also contains an iterative shift-add multiplier that stalls the pipeline, and resolves jumps and conditional branches by driving flush and set-pc to fetch. It sits between decode/register-read and writeback.

Parameters:
OP_WIDTH, 4, width of operation select
IALU_WORD_WIDTH, 16, operand/result width (>=4)
PC_WIDTH, 12, program counter width (<=IALU_WORD_WIDTH)
REG_IDX_WIDTH, 4, destination register index width

Ports:
clock  input  1  clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation on inputs is valid
in_op  input  OP_WIDTH  operation select
in_src1  input  IALU_WORD_WIDTH  operand 1
in_src2  input  IALU_WORD_WIDTH  operand 2
in_pc  input  PC_WIDTH  PC of the operation
in_imm  input  PC_WIDTH  branch offset, two's complement
in_rd  input  REG_IDX_WIDTH  destination register index
out_res  output  IALU_WORD_WIDTH  result (0 when out_res_valid low)
out_res_valid  output  1  out_res/out_rd valid for writeback
out_rd  output  REG_IDX_WIDTH  destination index of out_res
out_stall  output  1  upstream must hold inputs
out_flush  output  1  squash younger in-flight instructions
out_set_pc  output  1  load out_new_pc into fetch PC
out_new_pc  output  PC_WIDTH  jump/branch target

Behaviour:
- Reset: reset is asynchronous, active-high, on clock. All sampled registers, the FSM state (IDLE) and the multiplier registers clear. All outputs are 0 during reset and in the cycle after release.
- Op codes: 0 NOP, 1 ADD, 2 SUB (src1-src2), 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 MUL, 9 JMP, 10 BEQ, 11 BNE, 12 BLT (signed). Codes 13-15 behave as NOP.
- Shifts use src2[log2(IALU_WORD_WIDTH)-1:0]. Shift-in is zero.
- Arithmetic is modulo 2^IALU_WORD_WIDTH. No flags.
- Input stage:
  - On each posedge with out_stall=0, in_* are sampled.
  - With out_stall=1 the sampled registers hold their values.
  - A sample with in_valid=0 is stored as NOP.
- Single-cycle ops (1-7):
  - Result is combinational from the sampled registers, so it appears in the cycle after sampling (latency 1).
  - out_res_valid=1 and out_rd=sampled rd for that cycle.
- JMP:
  - new_pc = (src1+src2)[PC_WIDTH-1:0].
  - out_flush=out_set_pc=1 for exactly one cycle.
  - No writeback.
- BEQ/BNE/BLT:
  - Compare src1 with src2.
  - If taken, new_pc = in_pc + sign-extended in_imm, wrapping mod 2^PC_WIDTH, and out_flush=out_set_pc=1 for one cycle.
  - If not taken, all three outputs are 0.
  - No writeback.
- Squash: the operation sampled on the edge immediately after a cycle with out_flush=1 is forced to NOP.
- MUL FSM, states IDLE, BUSY, DONE:
  - IDLE->BUSY when the sampled op is MUL. In that first cycle: out_stall=1, multiplicand=src1, multiplier=src2, accumulator=0, count=IALU_WORD_WIDTH.
  - BUSY: each cycle, if multiplier[0] the accumulator adds the multiplicand. Then multiplicand<<=1, multiplier>>=1, count-=1. out_stall=1 and out_res_valid=0.
  - BUSY->DONE when count reaches 0, after IALU_WORD_WIDTH iterations.
  - DONE: out_res = low IALU_WORD_WIDTH bits of the accumulator, out_res_valid=1, out_stall=0. DONE->IDLE, and a new op is sampled on that edge.
  - Total latency is IALU_WORD_WIDTH+1 cycles from sample to result. Stall lasts IALU_WORD_WIDTH cycles.
  - Back-to-back MULs: DONE goes directly to BUSY if the newly sampled op is MUL.
- out_stall is a function of state only. It is never combinationally dependent on in_*.
- Reset mid-multiply aborts to IDLE with no result, and out_stall drops immediately (asynchronous).
- Simultaneous events:
  - A branch cannot coincide with MUL, because only one sampled op exists at a time.
  - A flush with out_stall=1 cannot occur.

Test Plan:
1. ADD 0x7FFF+0x0001, rd=3 -> next cycle out_res=0x8000, out_res_valid=1, out_rd=3. SUB 0x0000-0x0001 -> 0xFFFF.
2. SLL src1=0x0001, src2=0x0013 (shift 3) -> 0x0008. SRL 0x8000 by 15 -> 0x0001.
3. MUL 0x0012*0x0034 -> out_stall high 16 cycles, then out_res=0x03A8 valid for one cycle. Inputs changed during the stall are ignored. MUL 0xFFFF*0xFFFF -> 0x0001.
4. BEQ 5,5, in_pc=0x010, in_imm=0xFFC -> out_flush=out_set_pc=1, out_new_pc=0x00C for one cycle. The following ADD is squashed (out_res_valid=0). BNE 5,5 -> no flush. BLT 0xFFFF<0x0001 -> taken.
5. JMP src1=0x0FF0, src2=0x0020 -> out_new_pc=0x010 (wrap). No writeback.
6. Assert reset at MUL iteration 7 -> out_stall=0 immediately. After release all outputs are 0 and a following ADD 1+1 gives 2 with latency 1.
